// File: rtl/eth_tx_pkg.sv
// Shared Ethernet transmit definitions: arbiter state encoding and payload limit.
package eth_tx_pkg;

  localparam int unsigned pMAX_PAYLOAD_BYTES = 1500;

  typedef enum logic [2:0] {
    ARB,
    XFER,
    DRAIN,
    WAIT_START,
    WAIT_DONE
  } eth_tx_arb_state_t;

endpackage

// File: rtl/eth_tx_arb_if.sv
// Source-side and FIFO-side signals of the transmit arbiter.
// master: the arbiter; slave: the sources, FIFO and transmit controller.
interface eth_tx_arb_if #(
  parameter int unsigned pNUM_SRC = 2
);

  logic [pNUM_SRC-1:0]   Src_Valid;
  logic [8*pNUM_SRC-1:0] Src_Data;
  logic [pNUM_SRC-1:0]   Src_Last;
  logic [pNUM_SRC-1:0]   Src_Ready;
  logic                  Fifo_Full;
  logic                  Fifo_Wr;
  logic [7:0]            Fifo_Data;
  logic                  Fifo_Last;
  logic                  Tx_Idle;
  logic [pNUM_SRC-1:0]   Grant;
  logic                  Trunc_Err;

  modport master (
    input  Src_Valid, Src_Data, Src_Last, Fifo_Full, Tx_Idle,
    output Src_Ready, Fifo_Wr, Fifo_Data, Fifo_Last, Grant, Trunc_Err
  );

  modport slave (
    output Src_Valid, Src_Data, Src_Last, Fifo_Full, Tx_Idle,
    input  Src_Ready, Fifo_Wr, Fifo_Data, Fifo_Last, Grant, Trunc_Err
  );

endinterface

// File: rtl/eth_tx_rr_sel.sv
// Request vector + search start pointer -> one-hot winner.
// pPRIO_EN=1 ignores the pointer and always searches from index 0.
module eth_tx_rr_sel #(
  parameter int unsigned pNUM_SRC = 2,
  parameter bit          pPRIO_EN = 1'b0,
  parameter int unsigned pPTR_W   = $clog2(pNUM_SRC)
) (
  input  logic [pNUM_SRC-1:0] Req,
  input  logic [pPTR_W-1:0]   Ptr,
  output logic [pNUM_SRC-1:0] Gnt
);

  logic [pPTR_W-1:0] idx;
  logic              found;

  // First requester found searching upward from the start index, wrapping.
  always_comb begin
    Gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < pNUM_SRC; k++) begin
      idx = pPRIO_EN ? pPTR_W'(k) : pPTR_W'((32'(Ptr) + k) % pNUM_SRC);
      if (!found && Req[idx]) begin
        Gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arb.sv
// Packet-level arbiter feeding the transmit data FIFO from several sources.
// Build option ETH_TX_ARB_PRIO_EN: fixed priority (lowest index wins) instead
// of round-robin.
module eth_tx_arb
  import eth_tx_pkg::*;
#(
  parameter int unsigned pNUM_SRC   = 2,
  parameter int unsigned pMAX_BYTES = pMAX_PAYLOAD_BYTES
) (
  input  logic         Clk,
  input  logic         Rst,
  eth_tx_arb_if.master bus
);

  localparam int unsigned PTR_W    = $clog2(pNUM_SRC);
  localparam logic [10:0] LAST_CNT = 11'(pMAX_BYTES - 1);

  eth_tx_arb_state_t   rState;
  logic [pNUM_SRC-1:0] rGrant;
  logic [pNUM_SRC-1:0] sel_gnt;
  logic [pNUM_SRC-1:0] src_ready;
  logic [10:0]         rCnt;
  logic                rWr;
  logic [7:0]          rData;
  logic                rLast;
  logic                rTrunc;
  logic                accept;
  logic                sel_last;
  logic [7:0]          sel_data;
  logic [PTR_W-1:0]    sel_ptr;

`ifdef ETH_TX_ARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
  assign sel_ptr = '0;
`else
  localparam bit PRIO_EN = 1'b0;
  logic [PTR_W-1:0] rPtr;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] next_ptr;
  assign sel_ptr = rPtr;

  // Encode the winner and the pointer value just past it.
  always_comb begin
    win_idx = '0;
    for (int unsigned k = 0; k < pNUM_SRC; k++) begin
      if (sel_gnt[k]) win_idx = PTR_W'(k);
    end
    next_ptr = (win_idx == PTR_W'(pNUM_SRC - 1)) ? '0 : win_idx + 1'b1;
  end
`endif

  eth_tx_rr_sel #(
    .pNUM_SRC (pNUM_SRC),
    .pPRIO_EN (PRIO_EN),
    .pPTR_W   (PTR_W)
  ) u_sel (
    .Req (bus.Src_Valid),
    .Ptr (sel_ptr),
    .Gnt (sel_gnt)
  );

  // Owner may push only while the FIFO has room; draining ignores the FIFO.
  always_comb begin
    src_ready = '0;
    case (rState)
      XFER:    src_ready = rGrant & {pNUM_SRC{~bus.Fifo_Full}};
      DRAIN:   src_ready = rGrant;
      default: src_ready = '0;
    endcase
  end

  // Route the owner's byte and last flag; grant is one-hot so OR-merging is safe.
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < pNUM_SRC; k++) begin
      sel_data = sel_data | ({8{rGrant[k]}} & bus.Src_Data[8*k +: 8]);
    end
    sel_last = |(bus.Src_Last & rGrant);
    accept   = |(bus.Src_Valid & src_ready);
  end

  // Arbitration FSM with registered FIFO write and truncation outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rState <= ARB;
      rGrant <= '0;
      rCnt   <= '0;
      rWr    <= 1'b0;
      rData  <= '0;
      rLast  <= 1'b0;
      rTrunc <= 1'b0;
`ifndef ETH_TX_ARB_PRIO_EN
      rPtr   <= '0;
`endif
    end else begin
      rWr    <= 1'b0;
      rLast  <= 1'b0;
      rTrunc <= 1'b0;
      case (rState)
        ARB: begin
          rGrant <= '0;
          if ((|bus.Src_Valid) && bus.Tx_Idle) begin
            rGrant <= sel_gnt;
            rCnt   <= '0;
`ifndef ETH_TX_ARB_PRIO_EN
            rPtr   <= next_ptr;
`endif
            rState <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            rWr   <= 1'b1;
            rData <= sel_data;
            rCnt  <= rCnt + 11'd1;
            if (sel_last) begin
              rLast  <= 1'b1;
              rState <= WAIT_START;
            end else if (rCnt == LAST_CNT) begin
              rLast  <= 1'b1;
              rTrunc <= 1'b1;
              rState <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (accept && sel_last) rState <= WAIT_START;
        end
        WAIT_START: begin
          if (!bus.Tx_Idle) rState <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.Tx_Idle) begin
            rGrant <= '0;
            rState <= ARB;
          end
        end
        default: begin
          rGrant <= '0;
          rState <= ARB;
        end
      endcase
    end
  end

  assign bus.Src_Ready = src_ready;
  assign bus.Fifo_Wr   = rWr;
  assign bus.Fifo_Data = rData;
  assign bus.Fifo_Last = rLast;
  assign bus.Grant     = rGrant;
  assign bus.Trunc_Err = rTrunc;

endmodule
